// File: rtl/tex_pkg.sv
// Shared constants and state encoding for the TeX transform line sequencer.
package tex_pkg;

  localparam int LINE_W    = 6;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 16;
  localparam int PTR_W     = 12;
  localparam int FLD_W     = 6;
  localparam int START_LSB = 0;
  localparam int LEN_LSB   = 6;

  // Parked memory address: outside any line so an idle fetch is harmless.
  localparam logic [ADDR_W-1:0] IDLE_ADDR = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAP_REQ,
    S_MAP_WAIT,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_EMIT,
    S_NEXT,
    S_FIN
  } state_e;

endpackage

// File: rtl/tex_line_sequencer.sv
// Walks a line range: fetches each line's pointer word from the mapper, then
// streams that line's character pairs from memory with a valid/ready handshake.
module tex_line_sequencer
  import tex_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LINE_W-1:0] first_line,
  input  logic [LINE_W-1:0] last_line,
  output logic              busy,
  output logic              done,
  output logic [LINE_W-1:0] map_line,
  input  logic [PTR_W-1:0]  map_addr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_lhs,
  output logic [7:0]        out_rhs,
  output logic [LINE_W-1:0] out_line,
  output logic              out_eol,
  output logic              out_eof
);

  localparam logic [LINE_W-1:0] LINE_ONE = 1;
  localparam logic [FLD_W-1:0]  REM_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_e              state_q;
  logic [LINE_W-1:0]   last_q;
  logic [FLD_W-1:0]    rem_q;
  logic                busy_q, done_q, valid_q, eol_q, eof_q;
  logic [LINE_W-1:0]   map_line_q, out_line_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [7:0]          lhs_q, rhs_q;

  logic [FLD_W-1:0]    ptr_start, ptr_len;

  assign ptr_start = map_addr[START_LSB +: FLD_W];
  assign ptr_len   = map_addr[LEN_LSB +: FLD_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_q     <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      eol_q      <= 1'b0;
      eof_q      <= 1'b0;
      map_line_q <= '0;
      out_line_q <= '0;
      mem_addr_q <= IDLE_ADDR;
      lhs_q      <= '0;
      rhs_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            last_q <= last_line;
            busy_q <= 1'b1;
            if (last_line < first_line) begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              map_line_q <= first_line;
              state_q    <= S_MAP_REQ;
            end
          end
        end
        S_MAP_REQ: state_q <= S_MAP_WAIT;
        S_MAP_WAIT: begin
          // Zero-length lines produce no pairs and no eol marker.
          if (ptr_len == '0) begin
            state_q <= S_NEXT;
          end else begin
            mem_addr_q <= {{(ADDR_W-FLD_W){1'b0}}, ptr_start};
            rem_q      <= ptr_len;
            state_q    <= S_RD_ISSUE;
          end
        end
        S_RD_ISSUE: state_q <= S_RD_WAIT;
        S_RD_WAIT: begin
          lhs_q      <= mem_dout[DATA_W-1 -: 8];
          rhs_q      <= mem_dout[7:0];
          out_line_q <= map_line_q;
          eol_q      <= (rem_q == REM_ONE);
          eof_q      <= (rem_q == REM_ONE) && (map_line_q == last_q);
          valid_q    <= 1'b1;
          state_q    <= S_EMIT;
        end
        S_EMIT: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            if (rem_q > REM_ONE) begin
              mem_addr_q <= mem_addr_q + ADDR_ONE;
              rem_q      <= rem_q - REM_ONE;
              state_q    <= S_RD_ISSUE;
            end else begin
              mem_addr_q <= IDLE_ADDR;
              state_q    <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          // Compare before incrementing so last_line=63 never wraps.
          if (map_line_q == last_q) begin
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else begin
            map_line_q <= map_line_q + LINE_ONE;
            state_q    <= S_MAP_REQ;
          end
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign map_line  = map_line_q;
  assign mem_addr  = mem_addr_q;
  assign out_valid = valid_q;
  assign out_lhs   = lhs_q;
  assign out_rhs   = rhs_q;
  assign out_line  = out_line_q;
  assign out_eol   = eol_q;
  assign out_eof   = eof_q;

endmodule
